// File: rtl/cog_vid_queue_if.sv
// cog_vid_queue_if: WAITVID pair bundle between the cog/shifter side and the video queue
interface cog_vid_queue_if #(parameter int AW = 2);
   logic        enable, flush, push, stall, ack, underrun, clr_ur;
   logic [31:0] push_pixel, push_color, pixel, color;
   logic [AW:0] level;
   logic [7:0]  urcnt;
   modport master (
      output enable, flush, push, push_pixel, push_color, ack, clr_ur,
      input  stall, pixel, color, level, underrun, urcnt
   );
   modport slave (
      input  enable, flush, push, push_pixel, push_color, ack, clr_ur,
      output stall, pixel, color, level, underrun, urcnt
   );
endinterface

// File: rtl/cog_vid_queue.sv
// cog_vid_queue: FIFO of WAITVID {color, pixel} pairs feeding the cog video shifter,
// advancing one pair per shifter ack rising edge and counting stale reloads.
module cog_vid_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic           clk_cog,
   input  logic           ena,
   cog_vid_queue_if.slave vq
);
   logic [63:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [AW:0]   r_cnt;
   logic [31:0]   r_px, r_co;
   logic          r_fresh, r_ack_d, r_ur;
   logic [7:0]    r_urcnt;
   logic          w_stall, w_rise, w_acc, w_empty, w_ue, w_wr_fifo;
   assign w_empty   = r_cnt == '0;
   assign w_stall   = (r_cnt == (AW+1)'(DEPTH)) & r_fresh;
   assign w_rise    = vq.ack & ~r_ack_d & vq.enable;
   assign w_acc     = vq.push & ~w_stall;
   assign w_ue      = w_rise & w_empty & ~w_acc & ~r_fresh & ~vq.flush;
   // a push only lands in the FIFO when it cannot go straight to the output pair
   assign w_wr_fifo = ena & ~vq.flush & w_acc & (w_rise ? ~w_empty : (~w_empty | r_fresh));
   always_ff @(posedge clk_cog)
      if (w_wr_fifo) r_mem[r_wr] <= {vq.push_color, vq.push_pixel};
   always_ff @(posedge clk_cog) begin
      if (!ena) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_cnt   <= '0;
         r_px    <= '0;
         r_co    <= '0;
         r_fresh <= 1'b0;
         r_ack_d <= 1'b0;
         r_ur    <= 1'b0;
         r_urcnt <= '0;
      end else begin
         r_ack_d <= vq.ack & vq.enable;
         if (vq.clr_ur) begin
            r_ur    <= w_ue;
            r_urcnt <= {7'd0, w_ue};
         end else if (w_ue) begin
            r_ur    <= 1'b1;
            r_urcnt <= (r_urcnt == 8'hff) ? r_urcnt : r_urcnt + 8'd1;
         end
         if (vq.flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_px    <= '0;
            r_co    <= '0;
            r_fresh <= 1'b0;
         end else begin
            if (w_wr_fifo) r_wr <= r_wr + 1'b1;
            if (w_rise & ~w_empty) begin
               {r_co, r_px} <= r_mem[r_rd];
               r_rd         <= r_rd + 1'b1;
               r_fresh      <= 1'b1;
               if (!w_acc) r_cnt <= r_cnt - 1'b1;
            end else if (w_rise & w_acc) begin
               r_px    <= vq.push_pixel;
               r_co    <= vq.push_color;
               r_fresh <= 1'b1;
            end else if (w_rise) begin
               r_fresh <= 1'b0;
            end else if (w_acc) begin
               if (w_empty & ~r_fresh) begin
                  r_px    <= vq.push_pixel;
                  r_co    <= vq.push_color;
                  r_fresh <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end
      end
   end
   assign vq.stall    = w_stall;
   assign vq.pixel    = r_px;
   assign vq.color    = r_co;
   assign vq.level    = r_cnt + {{AW{1'b0}}, r_fresh};
   assign vq.underrun = r_ur;
   assign vq.urcnt    = r_urcnt;
endmodule

// File: tb/tb_cog_vid_queue.sv
// tb_cog_vid_queue: directed plan plus random traffic against a queue-based reference model
module tb_cog_vid_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 2;
   logic clk = 1'b0;
   logic ena = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   cog_vid_queue_if #(.AW(AW)) vif ();
   cog_vid_queue #(.DEPTH(DEPTH), .AW(AW)) dut (.clk_cog(clk), .ena(ena), .vq(vif.slave));
   always #5 clk = ~clk;
   logic [63:0] m_q[$];
   logic [31:0] m_px, m_co;
   bit          m_fresh, m_ackd, m_ur;
   int          m_urcnt;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic model_step();
      bit rise, acc, ue;
      logic [63:0] nw, cur;
      if (!ena) begin
         m_q.delete();
         m_px = '0; m_co = '0; m_fresh = 0; m_ackd = 0; m_ur = 0; m_urcnt = 0;
         return;
      end
      rise   = vif.ack && !m_ackd && vif.enable;
      m_ackd = vif.ack && vif.enable;
      acc    = vif.push && !(m_q.size() == DEPTH && m_fresh);
      nw     = {vif.push_color, vif.push_pixel};
      ue     = 0;
      if (vif.flush) begin
         m_q.delete();
         m_px = '0; m_co = '0; m_fresh = 0;
      end else if (rise) begin
         if (acc) m_q.push_back(nw);
         if (m_q.size() > 0) begin
            cur = m_q.pop_front();
            {m_co, m_px} = cur;
            m_fresh = 1;
         end else if (m_fresh) m_fresh = 0;
         else ue = 1;
      end else if (acc) begin
         if (m_q.size() == 0 && !m_fresh) begin
            {m_co, m_px} = nw;
            m_fresh = 1;
         end else m_q.push_back(nw);
      end
      if (vif.clr_ur) begin
         m_ur = ue; m_urcnt = ue ? 1 : 0;
      end else if (ue) begin
         m_ur = 1; m_urcnt = (m_urcnt < 255) ? m_urcnt + 1 : 255;
      end
   endtask
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("pixel", vif.pixel, m_px);
      check("color", vif.color, m_co);
      check("level", vif.level, m_q.size() + m_fresh);
      check("stall", vif.stall, (m_q.size() == DEPTH) && m_fresh);
      check("underrun", vif.underrun, m_ur);
      check("urcnt", vif.urcnt, m_urcnt);
   endtask
   task automatic idle();
      vif.enable = 1; vif.flush = 0; vif.push = 0; vif.ack = 0; vif.clr_ur = 0;
      vif.push_pixel = '0; vif.push_color = '0;
   endtask
   task automatic do_reset();
      idle();
      ena = 0;
      tick();
      ena = 1;
   endtask
   task automatic push1(input logic [31:0] px, input logic [31:0] co);
      vif.push = 1; vif.push_pixel = px; vif.push_color = co;
      tick();
      vif.push = 0;
   endtask
   task automatic ack_pulse();
      vif.ack = 1; tick();
      vif.ack = 0; tick();
   endtask
   initial begin
      idle();
      do_reset();
      check("rst_level", vif.level, 0);
      check("rst_pixel", vif.pixel, 0);
      push1(32'h0000_00aa, 32'h0302_0100);
      check("tp1_px", vif.pixel, 32'haa);
      check("tp1_co", vif.color, 32'h0302_0100);
      check("tp1_lvl", vif.level, 1);
      check("tp1_stall", vif.stall, 0);
      do_reset();
      for (int i = 1; i <= 5; i++) push1(i, ~i);
      check("full_lvl", vif.level, 5);
      check("full_stall", vif.stall, 1);
      push1(32'd6, 32'd6);
      check("full_ign", vif.level, 5);
      vif.ack = 1; tick();
      check("pop_px", vif.pixel, 2);
      check("pop_lvl", vif.level, 4);
      check("pop_stall", vif.stall, 0);
      vif.ack = 0; tick();
      for (int i = 3; i <= 5; i++) begin
         ack_pulse();
         check("drain_px", vif.pixel, i);
      end
      ack_pulse();
      check("stale_lvl", vif.level, 0);
      check("stale_ur", vif.underrun, 0);
      ack_pulse();
      check("ur_flag", vif.underrun, 1);
      check("ur_cnt", vif.urcnt, 1);
      check("ur_hold", vif.pixel, 5);
      do_reset();
      push1(32'd10, 32'd10);
      vif.ack = 1; push1(32'd11, 32'd11); vif.ack = 0;
      check("coin0_px", vif.pixel, 11);
      check("coin0_lvl", vif.level, 1);
      tick();
      push1(32'd12, 32'd12);
      push1(32'd13, 32'd13);
      vif.ack = 1; push1(32'd14, 32'd14); vif.ack = 0;
      check("coin2_px", vif.pixel, 12);
      check("coin2_lvl", vif.level, 3);
      tick();
      ack_pulse(); check("coin_ord1", vif.pixel, 13);
      ack_pulse(); check("coin_ord2", vif.pixel, 14);
      check("coin_nour", vif.underrun, 0);
      do_reset();
      for (int i = 0; i < 300; i++) ack_pulse();
      check("sat_cnt", vif.urcnt, 255);
      vif.clr_ur = 1; tick(); vif.clr_ur = 0;
      check("clr_ur", vif.underrun, 0);
      check("clr_cnt", vif.urcnt, 0);
      vif.clr_ur = 1; vif.ack = 1; tick(); vif.clr_ur = 0; vif.ack = 0;
      check("clr_ev_ur", vif.underrun, 1);
      check("clr_ev_cnt", vif.urcnt, 1);
      do_reset();
      push1(32'd7, 32'd7);
      vif.enable = 0;
      for (int i = 0; i < 6; i++) begin vif.ack = ~vif.ack; tick(); end
      vif.ack = 0; tick(); vif.enable = 1;
      check("dis_px", vif.pixel, 7);
      check("dis_lvl", vif.level, 1);
      check("dis_ur", vif.underrun, 0);
      do_reset();
      for (int i = 1; i <= 4; i++) push1(i, i);
      vif.flush = 1; push1(32'd99, 32'd99); vif.flush = 0;
      check("flush_lvl", vif.level, 0);
      check("flush_px", vif.pixel, 0);
      tick();
      check("flush_drop", vif.level, 0);
      for (int i = 1; i <= 3; i++) push1(i + 20, i);
      ack_pulse();
      ena = 0; tick(); ena = 1;
      check("mid_rst_lvl", vif.level, 0);
      check("mid_rst_px", vif.pixel, 0);
      check("mid_rst_co", vif.color, 0);
      for (int i = 0; i < 3000; i++) begin
         ena            = ($urandom_range(0, 199) != 0);
         vif.enable     = ($urandom_range(0, 7) != 0);
         vif.flush      = ($urandom_range(0, 59) == 0);
         vif.push       = $urandom_range(0, 1);
         vif.push_pixel = $urandom;
         vif.push_color = $urandom;
         vif.clr_ur     = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 2) == 0) vif.ack = ~vif.ack;
         tick();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cog_vid_queue.md
Name: cog_vid_queue

Overview:
- Upstream feeder for the cog video shifter. Buffers WAITVID {color, pixel} pairs issued by the cog in a small FIFO.
- Presents one pair at a time on the shifter's pixel/color inputs. Advances to the next pair on each rising edge of the shifter's ack.
- Back-pressures the cog through stall and records underruns, i.e. the shifter reloading stale data.
- Lives entirely in the clk_cog domain. ack arrives already synchronized by the shifter.

Parameters:
- DEPTH, 4, FIFO entries behind the output register; power of two, at least 2.
- AW, 2, log2(DEPTH); pointer width.

Ports:
- clk_cog  in  1  cog clock; all state updates on its rising edge.
- ena  in  1  synchronous active-low reset; ena=0 at a clk_cog edge resets all state.
- enable  in  1  shifter running (vid[30:29] != 0); ack edges ignored while low.
- flush  in  1  synchronous discard of all queued and presented data.
- push  in  1  cog issues a WAITVID pair this cycle.
- push_pixel  in  32  pixel word accompanying push.
- push_color  in  32  color word accompanying push.
- stall  out  1  queue full; cog must hold WAITVID; push ignored while high.
- ack  in  1  capture acknowledge from the shifter (level; a rising edge means the presented pair was loaded).
- pixel  out  32  pixel word presented to the shifter.
- color  out  32  color word presented to the shifter.
- level  out  AW+1  occupancy = FIFO count + fresh (0..DEPTH+1).
- underrun  out  1  sticky: the shifter consumed a pair that was already consumed.
- urcnt  out  8  saturating underrun count.
- clr_ur  in  1  clears underrun and urcnt.

Behaviour:
- State:
  - FIFO: wr/rd pointers of AW bits, count of AW+1 bits.
  - Output registers pixel/color.
  - fresh: the output pair has not yet been consumed.
  - ack_d: ack registered.
  - Sticky underrun flag and urcnt.
- Reset (ena=0): pointers=0, count=0, fresh=0, pixel=0, color=0, ack_d=0, underrun=0, urcnt=0. Outputs are valid from the first edge after ena rises.
- Priority per edge: reset > flush > normal operation.
- ack_rise = ack & ~ack_d & enable. ack_d <= ack & enable every cycle, so a rise after enable returns low counts once.
- stall = (count == DEPTH) & fresh. Purely a function of registered state, so it is combinational from flops.
- accept = push & ~stall.
- Normal-operation cases, evaluated on the same edge:
  - A: accept, no ack_rise, count==0, fresh==0. Write the push data directly to pixel/color; fresh<=1. Zero-cycle path to the shifter.
  - B: accept, no ack_rise, otherwise. Write to FIFO at wr; wr++; count++.
  - C: ack_rise, count>0. Load pixel/color from FIFO[rd]; rd++; fresh<=1.
    - With a simultaneous accept: write FIFO[wr]; wr++; count is unchanged.
    - Without accept: count--.
  - D: ack_rise, count==0, accept. Push data goes directly to pixel/color; fresh<=1; no underrun.
  - E: ack_rise, count==0, no accept.
    - If fresh==1: fresh<=0, pixel/color hold.
    - If fresh==0: underrun event; pixel/color hold (the shifter re-uses the last pair).
- Underrun event: underrun<=1; urcnt<=urcnt+1, saturating at 255.
  - clr_ur alone: underrun<=0, urcnt<=0.
  - clr_ur coinciding with an event: underrun<=1, urcnt<=1.
- Wrap-around: pointers wrap modulo DEPTH naturally. count distinguishes full from empty.
- Full boundary: with count==DEPTH and fresh==1, stall=1 and push is ignored. An ack_rise pops, and stall deasserts on the next cycle.
- Flush: pointers=0, count=0, fresh=0, pixel=0, color=0.
  - push in the same cycle is dropped.
  - underrun and urcnt are unaffected.
  - ack_d still updates.
- Latency:
  - Push into an empty, non-fresh queue is visible on pixel/color the next cycle.
  - Pop on ack_rise is visible the next cycle.
- Order is strictly FIFO. No entry is duplicated except the hold in case E.

Test Plan:
- Reset, then one push of pixel=0x0000_00AA, color=0x0302_0100 -> next cycle pixel=0x0000_00AA, color=0x0302_0100, level=1, stall=0.
- Push 5 pairs (pixel=1..5) with no ack -> level=5, stall=1. A 6th push is ignored. Pulse ack (enable=1) -> pixel=2, level=4, stall drops the cycle after.
- Fill with 1..5, then 5 ack pulses -> pixel sequence 2,3,4,5 with fresh cleared after the 5th. A 6th ack -> underrun=1, urcnt=1, pixel holds 5.
- Push coincident with ack_rise, at count=0/fresh=1 and at count=2 -> in both cases the new word is consumed in order and no underrun occurs. Level is 1 after the first case and unchanged (3) after the second.
- 300 ack pulses on an empty queue -> urcnt saturates at 255. clr_ur -> underrun=0, urcnt=0. clr_ur coincident with a further underrun -> underrun=1, urcnt=1.
- ack toggling with enable=0 -> no pops and no underruns.
- flush with 3 entries queued plus a simultaneous push -> level=0, pixel=0, the push is discarded.
- ena=0 mid-stream -> all outputs return to their reset values on the next edge.
